// File: rtl/fpadd_pkg.sv
// Shared types and constants for the FP adder scheduler.
package fpadd_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, RESP} sched_state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fp32_t;

  // Denormals count as zero: the alignment stage always inserts the implicit one.
  function automatic logic isZero(input logic [31:0] x);
    return x[EXP_MSB:EXP_LSB] == 8'h00;
  endfunction

endpackage

// File: rtl/fpadd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grantIdx
);

  always_comb begin
    int unsigned j;
    j        = 0;
    grant    = '0;
    grantIdx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (grant == '0 && req[IW'(j)]) begin
        grant[IW'(j)] = 1'b1;
        grantIdx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sequencing the shared FP adder datapath (align/add/normalize).
// Optional build macro FPADD_ZERO_BYPASS_EN: zero operands skip the datapath.
module fpadd_sched
  import fpadd_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ID_W         = 1,
  parameter int unsigned NORM_TIMEOUT = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_err,
  output logic [31:0]           dp_op_a,
  output logic [31:0]           dp_op_b,
  output logic                  dp_align_en,
  output logic                  dp_add_en,
  output logic                  dp_norm_start,
  input  logic                  dp_norm_done,
  input  logic [31:0]           dp_result,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(NORM_TIMEOUT + 1);

  sched_state_t       stateQ, stateD;
  logic [ID_W-1:0]    ptrQ, ptrD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grantIdx;
  fp32_t              selA, selB;
  logic [ID_W-1:0]    idD;
  logic [31:0]        opAD, opBD, resD;
  logic               errD, validD, alignD, addD, normStartD;

  rr_arbiter #(.N(NUM_REQ)) uArb (
    .req      (req_valid),
    .ptr      (ptrQ),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  // Operand mux for the granted requester.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        selA = req_a[i*32 +: 32];
        selB = req_b[i*32 +: 32];
      end
    end
  end

  always_comb begin
    stateD     = stateQ;
    ptrD       = ptrQ;
    cntD       = cntQ;
    idD        = rsp_id;
    opAD       = dp_op_a;
    opBD       = dp_op_b;
    resD       = rsp_result;
    errD       = rsp_err;
    validD     = rsp_valid;
    alignD     = 1'b0;
    addD       = 1'b0;
    normStartD = 1'b0;
    req_ready  = '0;
    unique case (stateQ)
      IDLE: begin
        req_ready = grant;
        if (grant != '0) begin
          stateD = ALIGN;
          alignD = 1'b1;
          idD    = grantIdx;
          opAD   = selA;
          opBD   = selB;
          ptrD   = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
`ifdef FPADD_ZERO_BYPASS_EN
          if (isZero(selA) || isZero(selB)) begin
            stateD = RESP;
            alignD = 1'b0;
            validD = 1'b1;
            errD   = 1'b0;
            resD   = (isZero(selA) && !isZero(selB)) ? selB : selA;
          end
`endif
        end
      end
      ALIGN: begin
        stateD = ADD;
        addD   = 1'b1;
      end
      ADD: begin
        stateD     = NORM;
        normStartD = 1'b1;
        cntD       = '0;
      end
      NORM: begin
        // Done takes priority over a timeout expiring in the same cycle.
        if (dp_norm_done) begin
          stateD = RESP;
          resD   = dp_result;
          errD   = 1'b0;
          validD = 1'b1;
        end else if (cntQ == CNT_W'(NORM_TIMEOUT - 1)) begin
          stateD = RESP;
          resD   = FP_QNAN;
          errD   = 1'b1;
          validD = 1'b1;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          stateD = IDLE;
          validD = 1'b0;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ        <= IDLE;
      ptrQ          <= '0;
      cntQ          <= '0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
      rsp_valid     <= 1'b0;
      dp_op_a       <= '0;
      dp_op_b       <= '0;
      dp_align_en   <= 1'b0;
      dp_add_en     <= 1'b0;
      dp_norm_start <= 1'b0;
      busy          <= 1'b0;
    end else begin
      stateQ        <= stateD;
      ptrQ          <= ptrD;
      cntQ          <= cntD;
      rsp_id        <= idD;
      rsp_result    <= resD;
      rsp_err       <= errD;
      rsp_valid     <= validD;
      dp_op_a       <= opAD;
      dp_op_b       <= opBD;
      dp_align_en   <= alignD;
      dp_add_en     <= addD;
      dp_norm_start <= normStartD;
      busy          <= (stateD != IDLE);
    end
  end

endmodule

// File: tb/tb_fpadd_sched.sv
// Scoreboard bench for fpadd_sched with a behavioural normalize-stage responder.
module tb_fpadd_sched;
  import fpadd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [31:0] dp_op_a, dp_op_b;
  logic        dp_align_en, dp_add_en, dp_norm_start;
  logic        dp_norm_done;
  logic [31:0] dp_result;
  logic        busy;

  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] res;
    logic        err;
  } rspExp_t;

  rspExp_t     sbQ[$];
  int          errors = 0;
  int          checks = 0;
  int          normDelay = 1;
  logic [31:0] dpVal = '0;
  int          expPtr = 0;

  fpadd_sched #(.NUM_REQ(2), .ID_W(1), .NORM_TIMEOUT(31)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_err       (rsp_err),
    .dp_op_a       (dp_op_a),
    .dp_op_b       (dp_op_b),
    .dp_align_en   (dp_align_en),
    .dp_add_en     (dp_add_en),
    .dp_norm_start (dp_norm_start),
    .dp_norm_done  (dp_norm_done),
    .dp_result     (dp_result),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic waitIdle(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc();
      smp();
      if (!busy) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Normalize responder: raises done on the normDelay-th NORM cycle (0 = never).
  initial begin
    int left;
    left = 0;
    dp_norm_done = 1'b0;
    dp_result = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      dp_norm_done = 1'b0;
      dp_result = 32'hDEAD_BEEF;
      if (!rst_n) begin
        left = 0;
      end else begin
        if (dp_norm_start) left = normDelay;
        if (left == 1) begin
          dp_norm_done = 1'b1;
          dp_result = dpVal;
          left = 0;
        end else if (left > 1) begin
          left--;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    rspExp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id=%0d result=%h, required no response", rsp_id, rsp_result);
        end else begin
          e = sbQ.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_result", rsp_result, e.res);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    int gnts;

    // Reset state
    smp();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dp_op_a", dp_op_a, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_strobes", 32'({dp_align_en, dp_add_en, dp_norm_start}), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Single request with done on the second NORM cycle
    cyc();
    req_a = {32'h0, 32'h3F80_0000};
    req_b = {32'h0, 32'h4000_0000};
    req_valid = 2'b01;
    normDelay = 2;
    dpVal = 32'h4040_0000;
    sbQ.push_back('{id: 1'b0, res: 32'h4040_0000, err: 1'b0});
    smp();
    check("single_req_ready", 32'(req_ready), 32'h1);
    expPtr = 1;
    cyc();
    req_valid = 2'b00;
    smp();
    check("single_align_t1", 32'({dp_align_en, dp_add_en, dp_norm_start}), 32'b100);
    check("single_op_a", dp_op_a, 32'h3F80_0000);
    check("single_op_b", dp_op_b, 32'h4000_0000);
    check("single_busy", 32'(busy), 32'd1);
    cyc(); smp();
    check("single_add_t2", 32'({dp_align_en, dp_add_en, dp_norm_start}), 32'b010);
    cyc(); smp();
    check("single_norm_t3", 32'({dp_align_en, dp_add_en, dp_norm_start}), 32'b001);
    cyc(); smp();
    check("single_no_rsp_t4", 32'(rsp_valid), 32'd0);
    cyc(); smp();
    check("single_rsp_t5", 32'(rsp_valid), 32'd1);
    cyc(); smp();
    check("single_idle_t6", 32'(busy), 32'd0);

    // Fairness with both requesters held valid
    normDelay = 1;
    req_a = {32'h4100_0000, 32'h4080_0000};
    req_b = {32'h3F80_0000, 32'h3F80_0000};
    gnts = 0;
    for (int i = 0; i < 200 && gnts < 4; i++) begin
      cyc();
      req_valid = 2'b11;
      smp();
      if (req_ready != 2'b00) begin
        check("fair_grant", 32'(req_ready), 32'(1 << expPtr));
        dpVal = 32'h4200_0000 + 32'(gnts);
        sbQ.push_back('{id: 1'(expPtr), res: dpVal, err: 1'b0});
        expPtr = (expPtr + 1) % 2;
        gnts++;
      end
    end
    check("fair_grant_count", 32'(gnts), 32'd4);
    cyc();
    req_valid = 2'b00;
    waitIdle("fair_drain");

    // Backpressure: response held for ten cycles, requester 0 kept waiting
    cyc();
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    dpVal = 32'h4300_0000;
    smp();
    check("bp_req_ready", 32'(req_ready), 32'b10);
    sbQ.push_back('{id: 1'b1, res: 32'h4300_0000, err: 1'b0});
    expPtr = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      cyc();
      req_valid = 2'b01;
      smp();
      if (rsp_valid) seen = 1'b1;
    end
    check("bp_rsp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(); smp();
      check("bp_valid_stable", 32'(rsp_valid), 32'd1);
      check("bp_id_stable", 32'(rsp_id), 32'd1);
      check("bp_result_stable", rsp_result, 32'h4300_0000);
      check("bp_no_accept", 32'(req_ready), 32'd0);
    end
    cyc();
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    smp();
    cyc(); smp();
    check("bp_idle_after", 32'(busy), 32'd0);

    // Normalize timeout
    cyc();
    normDelay = 0;
    req_a = {32'h0, 32'h3F80_0000};
    req_b = {32'h0, 32'h4000_0000};
    req_valid = 2'b01;
    sbQ.push_back('{id: 1'b0, res: FP_QNAN, err: 1'b1});
    smp();
    check("to_req_ready", 32'(req_ready), 32'b01);
    expPtr = 1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      req_valid = 2'b00;
      n++;
      smp();
      if (rsp_valid) seen = 1'b1;
    end
    check("to_latency", 32'(n), 32'd34);
    waitIdle("to_drain");

    // Done arriving on the same cycle the timeout expires
    cyc();
    normDelay = 31;
    dpVal = 32'h4400_0000;
    req_a = {32'h4000_0000, 32'h0};
    req_b = {32'h4040_0000, 32'h0};
    req_valid = 2'b10;
    sbQ.push_back('{id: 1'b1, res: 32'h4400_0000, err: 1'b0});
    smp();
    check("dw_req_ready", 32'(req_ready), 32'b10);
    expPtr = 0;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      req_valid = 2'b00;
      n++;
      smp();
      if (rsp_valid) seen = 1'b1;
    end
    check("dw_latency", 32'(n), 32'd34);
    waitIdle("dw_drain");

    // Reset during ADD
    normDelay = 1;
    cyc();
    req_a = {32'h4000_0000, 32'h3F80_0000};
    req_b = {32'h4000_0000, 32'h3F80_0000};
    req_valid = 2'b01;
    smp();
    check("rm_req_ready", 32'(req_ready), 32'b01);
    cyc();
    req_valid = 2'b00;
    smp();
    cyc(); smp();
    check("rm_in_add", 32'(dp_add_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_add_en", 32'(dp_add_en), 32'd0);
    check("rm_op_a", dp_op_a, 32'd0);
    check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(); smp();
    end
    cyc();
    req_valid = 2'b11;
    dpVal = 32'h4480_0000;
    smp();
    check("rm_ptr_zero", 32'(req_ready), 32'b01);
    sbQ.push_back('{id: 1'b0, res: 32'h4480_0000, err: 1'b0});
    expPtr = 1;
    cyc();
    req_valid = 2'b00;
    waitIdle("rm_drain");

    // Zero operand
    cyc();
    req_a = {32'h0, 32'h0000_0000};
    req_b = {32'h0, 32'hC120_0000};
    req_valid = 2'b01;
    smp();
    check("zb_req_ready", 32'(req_ready), 32'b01);
`ifdef FPADD_ZERO_BYPASS_EN
    sbQ.push_back('{id: 1'b0, res: 32'hC120_0000, err: 1'b0});
    cyc();
    req_valid = 2'b00;
    smp();
    check("zb_rsp_t1", 32'(rsp_valid), 32'd1);
    check("zb_no_align", 32'(dp_align_en), 32'd0);
    cyc(); smp();
    check("zb_idle", 32'(busy), 32'd0);
    check("zb_no_strobes", 32'({dp_align_en, dp_add_en, dp_norm_start}), 32'd0);
`else
    dpVal = 32'h4500_0000;
    sbQ.push_back('{id: 1'b0, res: 32'h4500_0000, err: 1'b0});
    cyc();
    req_valid = 2'b00;
    smp();
    check("zb_full_align", 32'(dp_align_en), 32'd1);
    check("zb_full_no_rsp", 32'(rsp_valid), 32'd0);
    waitIdle("zb_full_drain");
`endif

    cyc(); smp();
    cyc(); smp();
    check("scoreboard_drain", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpadd_sched.md
Name: fpadd_sched

Overview:
Multi-requester scheduler for the shared single-precision FP adder datapath (align -> add -> normalize).
- Accepts operand pairs from NUM_REQ requesters under round-robin arbitration.
- Sequences the datapath stages one operation at a time and returns the tagged result through a valid/ready response port.
- Sits between client blocks and the fpbus-connected alignment/add/normalize stages.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, requester-index width; must equal max(1, clog2(NUM_REQ))
NORM_TIMEOUT, 31, max cycles spent in NORM waiting for dp_norm_done before forced error completion

Ports:
clk  in  1  system clock
rst_n  in  1  reset
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*32  operand A per requester, IEEE-754 single, slice i = [32i+31:32i]
req_b  in  NUM_REQ*32  operand B per requester, same packing
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  ID_W  index of requester that owns the result
rsp_result  out  32  sum, IEEE-754 single
rsp_err  out  1  normalize timeout occurred; rsp_result = 32'h7FC0_0000
dp_op_a  out  32  operand A driven to datapath (sign/exponent/mantissa fields)
dp_op_b  out  32  operand B driven to datapath
dp_align_en  out  1  one-cycle strobe: alignment outputs valid, datapath captures them
dp_add_en  out  1  one-cycle strobe: mantissa add stage captures
dp_norm_start  out  1  one-cycle strobe: start normalize
dp_norm_done  in  1  normalize finished, dp_result valid this cycle
dp_result  in  32  datapath result
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; round-robin pointer 0; timeout counter 0.
- Reset mid-operation aborts it. No response is produced and the pending request is lost; the requester must re-issue.
- States: IDLE, ALIGN, ADD, NORM, RESP.
- IDLE arbitration:
  - Combinational round-robin grant: start search at pointer and take the first i with req_valid[i].
  - req_ready[i] = 1 for the granted i only, and only in IDLE. Transfer occurs when req_valid & req_ready.
  - On transfer: latch operands into dp_op_a/dp_op_b, latch id, set pointer = (i+1) mod NUM_REQ, go to ALIGN.
  - No valid requests: stay in IDLE, pointer unchanged.
- ALIGN: dp_align_en = 1 for exactly one cycle -> ADD.
- ADD: dp_add_en = 1 for exactly one cycle -> NORM.
- NORM:
  - dp_norm_start = 1 on the first NORM cycle only; clear timeout counter on entry.
  - Sample dp_norm_done every NORM cycle, including the first.
  - done = 1: rsp_result <= dp_result, rsp_err <= 0 -> RESP.
  - Counter reaches NORM_TIMEOUT without done: rsp_result <= 32'h7FC0_0000, rsp_err <= 1 -> RESP.
  - dp_norm_done outside NORM is ignored.
- RESP:
  - rsp_valid = 1; rsp_id, rsp_result and rsp_err stay stable until rsp_valid & rsp_ready -> IDLE.
  - Requests are not accepted in RESP; one IDLE cycle always separates operations.
- Latency: request accepted in cycle T -> align strobe T+1, add strobe T+2, norm start T+3, earliest rsp_valid T+4.
- Simultaneous events:
  - rsp_ready high in the same cycle rsp_valid first rises completes the handshake that cycle.
  - dp_norm_done and timeout in the same cycle: done wins.
- dp_op_a/dp_op_b hold their values from transfer until the next transfer.

Optional Feature:
FPADD_ZERO_BYPASS_EN.
- Defined: an operand whose exponent field is 8'h00 is treated as zero.
  - If either operand is zero, IDLE skips the datapath and goes straight to RESP next cycle with rsp_result = the other operand (A if both are zero) and rsp_err = 0.
  - No dp_* strobes are issued; response latency is T+1.
  - Required because the alignment stage always inserts the implicit one.
- Undefined: every operation follows the full ALIGN/ADD/NORM sequence.

Decomposition:
- Package fpadd_pkg:
  - typedef enum logic [2:0] sched_state_t {IDLE, ALIGN, ADD, NORM, RESP}.
  - constants FP_QNAN = 32'h7FC0_0000, EXP_MSB = 30, EXP_LSB = 23.
  - typedef struct packed fp32_t {sign, exponent[7:0], mantissa[22:0]}.
- One sub-module: rr_arbiter (parameter N). Inputs: req vector and pointer. Outputs: one-hot grant and grant index.

Test Plan:
- Single request: req0 A=32'h3F80_0000, B=32'h4000_0000, model dp_norm_done at 2nd NORM cycle with dp_result 32'h4040_0000 -> rsp_valid at T+5, rsp_id=0, rsp_result=32'h4040_0000, strobes at T+1/T+2/T+3.
- Fairness: req0 and req1 held valid continuously -> grants alternate 0,1,0,1; no requester waits more than one operation.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_id/rsp_result stable; req_ready all 0; then rsp_ready=1 -> IDLE next cycle.
- Timeout: dp_norm_done never asserted -> after NORM_TIMEOUT(31) NORM cycles, rsp_err=1, rsp_result=32'h7FC0_0000.
- Reset mid-op: assert rst_n=0 during ADD -> all outputs 0 immediately, no response after release, next request granted from pointer 0.
- Zero bypass (FPADD_ZERO_BYPASS_EN): A=32'h0000_0000, B=32'hC120_0000 -> rsp_result=32'hC120_0000 at T+1, no dp_* strobes; without macro -> full sequence.
